hpc2_rand_source: RTL and testbench

Fresh-randomness producer for the masked HPC2 multipliers in the S-box datapath. It is seeded over a 32-bit word handshake and expands the seed with a 128-bit Fibonacci LFSR. Each accepted handshake delivers one `num_quad(NUM_SHARES) * BIT_WIDTH`-bit mask word, and the block never reuses a word. It sits between the top-level seed interface and the `in_r` ports of the gadgets.

---
 rtl/hpc2_rand_source_pkg.sv | 13 +
 rtl/hpc2_rand_source_if.sv | 18 +
 rtl/lfsr128_advance.sv | 17 +
 rtl/hpc2_rand_source.sv | 76 +++++++
 tb/tb_hpc2_rand_source.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/hpc2_rand_source_pkg.sv
// hpc2_rand_source_pkg: LFSR constants, FSM states and width helper for hpc2_rand_source
package hpc2_rand_source_pkg;
  localparam int RAND_LFSR_WIDTH = 128;
  localparam int RAND_SEED_WORDS = 4;
  localparam int RAND_TAP_0 = 127;
  localparam int RAND_TAP_1 = 125;
  localparam int RAND_TAP_2 = 100;
  localparam int RAND_TAP_3 = 98;
  typedef enum logic [1:0] {LOAD, WARMUP, RUN} rand_state_t;
  function automatic int num_quad(input int n);
    return n * (n - 1) / 2;
  endfunction
endpackage

// File: rtl/hpc2_rand_source_if.sv
// hpc2_rand_source_if: seed word and mask word handshakes of hpc2_rand_source
interface hpc2_rand_source_if #(parameter int R_W = 2);
  logic [31:0] in_seed;
  logic in_seed_valid;
  logic out_seed_ready;
  logic [R_W-1:0] out_r;
  logic out_r_valid;
  logic in_r_ready;
  logic out_reseed_req;
  modport master(
    input in_seed, in_seed_valid, in_r_ready,
    output out_seed_ready, out_r, out_r_valid, out_reseed_req
  );
  modport slave(
    output in_seed, in_seed_valid, in_r_ready,
    input out_seed_ready, out_r, out_r_valid, out_reseed_req
  );
endinterface

// File: rtl/lfsr128_advance.sv
// lfsr128_advance: combinational STEPS bit-steps of the 128-bit Fibonacci LFSR
module lfsr128_advance
  import hpc2_rand_source_pkg::*;
#(
  parameter int STEPS = 1
) (
  input  logic [RAND_LFSR_WIDTH-1:0] s_in,
  output logic [RAND_LFSR_WIDTH-1:0] s_out
);
  // unrolled shift-left with feedback into bit 0
  always_comb begin
    s_out = s_in;
    for (int i = 0; i < STEPS; i++)
      s_out = {s_out[RAND_LFSR_WIDTH-2:0],
               s_out[RAND_TAP_0] ^ s_out[RAND_TAP_1] ^ s_out[RAND_TAP_2] ^ s_out[RAND_TAP_3]};
  end
endmodule

// File: rtl/hpc2_rand_source.sv
// hpc2_rand_source: seeded LFSR mask-word source for HPC2 gadgets; RAND_RESEED_EN adds periodic reseed requests
module hpc2_rand_source
  import hpc2_rand_source_pkg::*;
#(
  parameter int NUM_SHARES      = 2,
  parameter int BIT_WIDTH       = 2,
  parameter int WARMUP_CYCLES   = 16,
  parameter int RESEED_INTERVAL = 65536
) (
  input logic in_clock,
  input logic in_reset,
  hpc2_rand_source_if.master bus
);
  localparam int R_W = num_quad(NUM_SHARES) * BIT_WIDTH;
  localparam int WC_W = WARMUP_CYCLES > 0 ? $clog2(WARMUP_CYCLES + 1) : 1;
  if (R_W > 64 || R_W < 1 || RESEED_INTERVAL < 1) begin : g_bad_cfg
    $error("hpc2_rand_source: mask width must be 1..64 and RESEED_INTERVAL positive");
  end
  rand_state_t state, state_nx;
  logic [RAND_LFSR_WIDTH-1:0] s, s_nx, s_adv, s_mix;
  logic [1:0] word, word_nx;
  logic [WC_W-1:0] warm, warm_nx;
  logic seed_hs, r_hs, last_word, warm_done, reseed_hit;
  lfsr128_advance #(.STEPS(R_W)) u_adv (.s_in(s), .s_out(s_adv));
  assign seed_hs   = state == LOAD && bus.in_seed_valid;
  assign r_hs      = state == RUN && bus.in_r_ready;
  assign last_word = seed_hs && word == 2'(RAND_SEED_WORDS - 1);
  assign warm_done = state == WARMUP && warm == WC_W'(1);
  assign s_mix     = s ^ (RAND_LFSR_WIDTH'(bus.in_seed) << {word, 5'd0});
  assign bus.out_seed_ready = state == LOAD;
  assign bus.out_r_valid    = state == RUN;
  assign bus.out_r          = s[R_W-1:0];
  // next state: seed mixing with zero-state escape, warmup advances, one advance per handshake
  always_comb begin
    state_nx = last_word ? (WARMUP_CYCLES > 0 ? WARMUP : RUN) :
               warm_done ? RUN : reseed_hit ? LOAD : state;
    s_nx     = seed_hs ? {s_mix[RAND_LFSR_WIDTH-1:1], s_mix[0] | (last_word && s_mix == '0)} :
               (state == WARMUP || r_hs) ? s_adv : s;
    word_nx  = seed_hs ? word + 2'd1 : word;
    warm_nx  = last_word ? WC_W'(WARMUP_CYCLES) : state == WARMUP ? warm - WC_W'(1) : warm;
  end
  // state register
  always_ff @(posedge in_clock) begin
    if (!in_reset) begin
      state <= LOAD;
      s     <= '0;
      word  <= '0;
      warm  <= '0;
    end else begin
      state <= state_nx;
      s     <= s_nx;
      word  <= word_nx;
      warm  <= warm_nx;
    end
  end
`ifdef RAND_RESEED_EN
  localparam int CNT_W = $clog2(RESEED_INTERVAL + 1);
  logic [CNT_W-1:0] cnt;
  logic seeded;
  assign reseed_hit         = r_hs && cnt == CNT_W'(RESEED_INTERVAL - 1);
  assign bus.out_reseed_req = state == LOAD && seeded;
  // count accepted outputs; after the first full seed any return to LOAD is a reseed
  always_ff @(posedge in_clock) begin
    if (!in_reset) begin
      cnt    <= '0;
      seeded <= 1'b0;
    end else begin
      cnt    <= reseed_hit ? '0 : r_hs ? cnt + CNT_W'(1) : cnt;
      seeded <= seeded | last_word;
    end
  end
`else
  assign reseed_hit         = 1'b0;
  assign bus.out_reseed_req = 1'b0;
`endif
endmodule

// File: tb/tb_hpc2_rand_source.sv
// tb_hpc2_rand_source: directed checks of two hpc2_rand_source instances (R_W=2 no warmup, R_W=48 warmup 16)
module tb_hpc2_rand_source;
  localparam int RW_A = 2;
  localparam int RW_B = 48;
  localparam int WARM_B = 16;
`ifdef RAND_RESEED_EN
  localparam int N_HS = 2;
`else
  localparam int N_HS = 5;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] seed = '0;
  logic seed_valid = 1'b0;
  logic r_ready = 1'b0;
  logic [127:0] m_a, m_b;
  int n_chk = 0;
  int n_pass = 0;
  int cyc;
  always #5 clk = ~clk;
  hpc2_rand_source_if #(.R_W(RW_A)) bus_a ();
  hpc2_rand_source_if #(.R_W(RW_B)) bus_b ();
  assign bus_a.in_seed       = seed;
  assign bus_a.in_seed_valid = seed_valid;
  assign bus_a.in_r_ready    = r_ready;
  assign bus_b.in_seed       = seed;
  assign bus_b.in_seed_valid = seed_valid;
  assign bus_b.in_r_ready    = r_ready;
  hpc2_rand_source #(.NUM_SHARES(2), .BIT_WIDTH(2), .WARMUP_CYCLES(0), .RESEED_INTERVAL(3))
    u_dut_a (.in_clock(clk), .in_reset(rst_n), .bus(bus_a));
  hpc2_rand_source #(.NUM_SHARES(4), .BIT_WIDTH(8), .WARMUP_CYCLES(WARM_B), .RESEED_INTERVAL(3))
    u_dut_b (.in_clock(clk), .in_reset(rst_n), .bus(bus_b));
  function automatic logic [127:0] adv(input logic [127:0] s, input int steps);
    for (int i = 0; i < steps; i++) s = {s[126:0], s[127] ^ s[125] ^ s[100] ^ s[98]};
    return s;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    seed_valid = 1'b0;
    r_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    m_a = '0;
    m_b = '0;
  endtask
  task automatic send_word(input logic [31:0] w);
    seed = w;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
  endtask
  task automatic load(input logic [127:0] words);
    for (int k = 0; k < 4; k++) send_word(words[32*k +: 32]);
    m_a ^= words;
    m_b ^= words;
    if (m_a == '0) m_a = 128'd1;
    if (m_b == '0) m_b = 128'd1;
    m_b = adv(m_b, WARM_B * RW_B);
  endtask
  task automatic wait_b(output int cycles);
    cycles = 1;
    seed = 32'hffff_ffff;
    while (!bus_b.out_r_valid && cycles < 40) begin
      seed_valid = cycles[0];
      tick();
      cycles++;
    end
    seed_valid = 1'b0;
  endtask
  task automatic hs(input int n);
    r_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      m_a = adv(m_a, RW_A);
      m_b = adv(m_b, RW_B);
      check("hs_a", 64'(bus_a.out_r), 64'(m_a[RW_A-1:0]));
      check("hs_b", 64'(bus_b.out_r), 64'(m_b[RW_B-1:0]));
    end
    r_ready = 1'b0;
  endtask
  initial begin
    do_reset();
    check("rst_r_a", 64'(bus_a.out_r), 64'd0);
    check("rst_valid_a", 64'(bus_a.out_r_valid), 64'd0);
    check("rst_seed_ready_a", 64'(bus_a.out_seed_ready), 64'd1);
    check("rst_reseed_a", 64'(bus_a.out_reseed_req), 64'd0);
    check("rst_r_b", 64'(bus_b.out_r), 64'd0);
    check("rst_valid_b", 64'(bus_b.out_r_valid), 64'd0);
    load(128'd1);
    check("seed1_valid_a", 64'(bus_a.out_r_valid), 64'd1);
    check("seed1_r_a", 64'(bus_a.out_r), 64'h1);
    check("seed1_ready_a", 64'(bus_a.out_seed_ready), 64'd0);
    check("seed1_valid_b", 64'(bus_b.out_r_valid), 64'd0);
    check("seed1_ready_b", 64'(bus_b.out_seed_ready), 64'd0);
    wait_b(cyc);
    check("warmup_latency", 64'(cyc), 64'(WARM_B + 1));
    check("warm_r_b", 64'(bus_b.out_r), 64'(m_b[RW_B-1:0]));
    check("gated_r_a", 64'(bus_a.out_r), 64'h1);
    check("reseed_req_run", 64'(bus_a.out_reseed_req), 64'd0);
    for (int i = 0; i < 10; i++) begin
      seed_valid = i[0];
      tick();
      check("hold_a", 64'(bus_a.out_r), 64'(m_a[RW_A-1:0]));
      check("hold_b", 64'(bus_b.out_r), 64'(m_b[RW_B-1:0]));
    end
    seed_valid = 1'b0;
    hs(1);
    check("basic_adv_a", 64'(bus_a.out_r), 64'h0);
    hs(N_HS - 1);
    do_reset();
    load(128'd0);
    check("zero_r_a", 64'(bus_a.out_r), 64'h1);
    wait_b(cyc);
    check("zero_r_b", 64'(bus_b.out_r), 64'(m_b[RW_B-1:0]));
    do_reset();
    send_word(32'h5);
    send_word(32'h7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_a = '0;
    m_b = '0;
    check("midrst_r_a", 64'(bus_a.out_r), 64'd0);
    check("midrst_ready_a", 64'(bus_a.out_seed_ready), 64'd1);
    check("midrst_ready_b", 64'(bus_b.out_seed_ready), 64'd1);
    send_word(32'hdead_beef);
    send_word(32'h0123_4567);
    send_word(32'h89ab_cdef);
    check("midrst_partial_valid_a", 64'(bus_a.out_r_valid), 64'd0);
    check("midrst_partial_ready_a", 64'(bus_a.out_seed_ready), 64'd1);
    send_word(32'h0f0f_1234);
    m_a = 128'h0f0f_1234_89ab_cdef_0123_4567_dead_beef;
    m_b = adv(m_a, WARM_B * RW_B);
    check("midrst_valid_a", 64'(bus_a.out_r_valid), 64'd1);
    check("midrst_r_a", 64'(bus_a.out_r), 64'h3);
    wait_b(cyc);
    check("midrst_r_b", 64'(bus_b.out_r), 64'(m_b[RW_B-1:0]));
    hs(2);
`ifdef RAND_RESEED_EN
    do_reset();
    load(128'h1357_9bdf_2468_ace0_cafe_f00d_0000_0002);
    wait_b(cyc);
    hs(3);
    check("reseed_valid_a", 64'(bus_a.out_r_valid), 64'd0);
    check("reseed_valid_b", 64'(bus_b.out_r_valid), 64'd0);
    check("reseed_req_a", 64'(bus_a.out_reseed_req), 64'd1);
    check("reseed_req_b", 64'(bus_b.out_reseed_req), 64'd1);
    check("reseed_ready_a", 64'(bus_a.out_seed_ready), 64'd1);
    load(128'd1);
    check("reseed_r_a", 64'(bus_a.out_r), 64'(m_a[RW_A-1:0]));
    check("reseed_done_req_a", 64'(bus_a.out_reseed_req), 64'd0);
    wait_b(cyc);
    check("reseed_r_b", 64'(bus_b.out_r), 64'(m_b[RW_B-1:0]));
    hs(2);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
